multicycle_ctrl: RTL and testbench

Multi-cycle sequencer for the RV32I core. It owns the program counter and instruction register, and steps each instruction through fetch, decode, execute, memory and writeback. It drives the instruction/data memory handshakes and the register-file write enable, and resolves branches and jumps from the decoder's control strobes and the ALU result. It sits between the memories and the decoder/ALU/register-file datapath.

---
 rtl/multicycle_ctrl_if.sv | 78 +++++++
 rtl/multicycle_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_if.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl_if
//
// Purpose:
//   Bundles every signal between the multi-cycle sequencer and its
//   surroundings: the instruction memory, the data memory, the decoder
//   strobes, the ALU/register-file datapath and the status outputs.
//   Clock and reset are not part of the bundle.
//
// Modports:
//   master - the sequencer (multicycle_ctrl): drives requests, inst, pc,
//            rf_we, wb_sel, retire, trap; samples acks, decoder strobes,
//            immediate, rs1 data and ALU flags.
//   slave  - the environment (memories + datapath), mirror image.
//
// Signal summary (XLEN = datapath width):
//   imem_req/imem_addr/imem_ack/imem_rdata   instruction fetch handshake
//   inst                                     instruction register to decoder
//   inst_legal, s_jump, s_jalr, s_branch,
//   s_branch_zero, s_load, s_store           decoder strobes
//   imm, rs1_data, alu_result, alu_zero      datapath operands and results
//   dmem_req/dmem_we/dmem_ack                data access handshake
//   rf_we, wb_sel                            register-file write control
//   pc, retire, trap                         status
// -----------------------------------------------------------------------------
interface multicycle_ctrl_if #(
   parameter int XLEN = 32
);
   // instruction memory
   logic            imem_req;
   logic [XLEN-1:0] imem_addr;
   logic            imem_ack;
   logic [XLEN-1:0] imem_rdata;

   // decoder
   logic [XLEN-1:0] inst;
   logic            inst_legal;
   logic            s_jump;
   logic            s_jalr;
   logic            s_branch;
   logic            s_branch_zero;
   logic            s_load;
   logic            s_store;

   // datapath
   logic [XLEN-1:0] imm;
   logic [XLEN-1:0] rs1_data;
   logic [XLEN-1:0] alu_result;
   logic            alu_zero;

   // data memory
   logic            dmem_req;
   logic            dmem_we;
   logic            dmem_ack;

   // register-file write control and status
   logic            rf_we;
   logic [1:0]      wb_sel;
   logic [XLEN-1:0] pc;
   logic            retire;
   logic            trap;

   modport master (
      output imem_req, imem_addr, inst, dmem_req, dmem_we,
             rf_we, wb_sel, pc, retire, trap,
      input  imem_ack, imem_rdata, inst_legal,
             s_jump, s_jalr, s_branch, s_branch_zero, s_load, s_store,
             imm, rs1_data, alu_result, alu_zero, dmem_ack
   );

   modport slave (
      input  imem_req, imem_addr, inst, dmem_req, dmem_we,
             rf_we, wb_sel, pc, retire, trap,
      output imem_ack, imem_rdata, inst_legal,
             s_jump, s_jalr, s_branch, s_branch_zero, s_load, s_store,
             imm, rs1_data, alu_result, alu_zero, dmem_ack
   );
endinterface

// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
//
// Purpose:
//   Multi-cycle sequencer for the RV32I core. Owns the program counter and
//   the instruction register and walks each instruction through
//   FETCH -> DECODE -> EXEC -> (MEM) -> WB. Resolves jumps and branches from
//   the decoder strobes and the ALU zero flag, drives both memory handshakes
//   and the register-file write strobe, and latches a sticky trap on an
//   illegal instruction or a misaligned control-flow target.
//
// Parameters:
//   XLEN      datapath width
//   RESET_PC  pc loaded by reset
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous, active-high reset
//   bus   multicycle_ctrl_if.master (see interface file for signal list)
//
// All outputs are decoded from registered state; imem_req additionally
// gated by !rst. No output depends combinationally on an ack.
// -----------------------------------------------------------------------------
module multicycle_ctrl #(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   multicycle_ctrl_if.master bus
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_TRAP   = 3'd5
   } state_t;

   localparam logic [1:0] WB_ALU  = 2'd0;
   localparam logic [1:0] WB_LOAD = 2'd1;
   localparam logic [1:0] WB_LINK = 2'd2;

   // --------------------------------------------------------------------------
   // State and registered outputs
   // --------------------------------------------------------------------------
   state_t          state_q;
   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] inst_q;
   logic [XLEN-1:0] npc_q;
   logic            trap_q;
   logic            rf_we_q;
   logic            retire_q;
   logic            dmem_req_q;
   logic            dmem_we_q;
   logic [1:0]      wb_sel_q;

   // --------------------------------------------------------------------------
   // Next-pc resolution (meaningful only while in EXEC)
   // --------------------------------------------------------------------------
   logic [XLEN-1:0] jalr_sum;
   logic [XLEN-1:0] pc_rel;
   logic [XLEN-1:0] pc_seq;
   logic [XLEN-1:0] npc_d;
   logic            br_taken;
   logic            redirect;
   logic            misalign;
   logic            rf_we_d;
   logic [1:0]      wb_sel_d;
   logic            mem_op;

   always_comb begin
      jalr_sum = bus.rs1_data + bus.imm;
      pc_rel   = pc_q + bus.imm;
      pc_seq   = pc_q + XLEN'(4);
      br_taken = bus.s_branch && (bus.alu_zero == bus.s_branch_zero);
      redirect = bus.s_jalr || bus.s_jump || br_taken;

      // jalr wins over a simultaneous s_jump, as the decoder raises both
      if (bus.s_jalr) begin
         npc_d = {jalr_sum[XLEN-1:1], 1'b0};
      end else if (bus.s_jump || br_taken) begin
         npc_d = pc_rel;
      end else begin
         npc_d = pc_seq;
      end

      // Bit 0 is already cleared for jalr; bit 1 set means a target that is
      // not word aligned. Fall-through pc+4 is never checked.
      misalign = redirect && npc_d[1];

      mem_op  = bus.s_load || bus.s_store;
      rf_we_d = !(bus.s_store || bus.s_branch);

      if (bus.s_jump) begin
         wb_sel_d = WB_LINK;
      end else if (bus.s_load) begin
         wb_sel_d = WB_LOAD;
      end else begin
         wb_sel_d = WB_ALU;
      end
   end

   // The ALU result itself is consumed by the register file; branch resolution
   // only needs the zero flag.
   logic unused_alu_result;
   assign unused_alu_result = ^bus.alu_result;

   // --------------------------------------------------------------------------
   // Sequencer
   // --------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_FETCH;
         pc_q       <= RESET_PC;
         inst_q     <= '0;
         npc_q      <= '0;
         trap_q     <= 1'b0;
         rf_we_q    <= 1'b0;
         retire_q   <= 1'b0;
         dmem_req_q <= 1'b0;
         dmem_we_q  <= 1'b0;
         wb_sel_q   <= WB_ALU;
      end else begin
         // one-cycle pulses, re-armed only on entry to WB
         rf_we_q  <= 1'b0;
         retire_q <= 1'b0;

         case (state_q)
            S_FETCH: begin
               if (bus.imem_ack) begin
                  inst_q  <= bus.imem_rdata;
                  state_q <= S_DECODE;
               end
            end

            S_DECODE: begin
               if (!bus.inst_legal) begin
                  trap_q  <= 1'b1;
                  state_q <= S_TRAP;
               end else begin
                  state_q <= S_EXEC;
               end
            end

            S_EXEC: begin
               npc_q <= npc_d;
               if (misalign) begin
                  trap_q  <= 1'b1;
                  state_q <= S_TRAP;
               end else if (mem_op) begin
                  dmem_req_q <= 1'b1;
                  dmem_we_q  <= bus.s_store;
                  state_q    <= S_MEM;
               end else begin
                  rf_we_q  <= rf_we_d;
                  retire_q <= 1'b1;
                  wb_sel_q <= wb_sel_d;
                  state_q  <= S_WB;
               end
            end

            S_MEM: begin
               if (bus.dmem_ack) begin
                  dmem_req_q <= 1'b0;
                  dmem_we_q  <= 1'b0;
                  rf_we_q    <= rf_we_d;
                  retire_q   <= 1'b1;
                  wb_sel_q   <= wb_sel_d;
                  state_q    <= S_WB;
               end
            end

            S_WB: begin
               pc_q    <= npc_q;
               state_q <= S_FETCH;
            end

            S_TRAP: begin
               // sticky: only rst leaves this state
               state_q <= S_TRAP;
            end

            default: begin
               trap_q  <= 1'b1;
               state_q <= S_TRAP;
            end
         endcase
      end
   end

   // --------------------------------------------------------------------------
   // Outputs
   // --------------------------------------------------------------------------
   assign bus.imem_req  = (state_q == S_FETCH) && !rst;
   assign bus.imem_addr = pc_q;
   assign bus.inst      = inst_q;
   assign bus.dmem_req  = dmem_req_q;
   assign bus.dmem_we   = dmem_we_q;
   assign bus.rf_we     = rf_we_q;
   assign bus.wb_sel    = wb_sel_q;
   assign bus.pc        = pc_q;
   assign bus.retire    = retire_q;
   assign bus.trap      = trap_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl
//
// Directed bench for multicycle_ctrl. Inputs change 1 time unit after the
// rising edge and outputs are checked at the same point, so each "cycle" below
// is the state visible between two rising edges. RESET_PC is 0x100.
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl;

   localparam logic [31:0] RPC  = 32'h0000_0100;
   localparam logic [31:0] ADDI = 32'h0050_0093;

   logic clk;
   logic rst;
   int   n_vec;
   int   n_bad;

   multicycle_ctrl_if #(.XLEN(32)) bus ();

   multicycle_ctrl #(
      .XLEN     (32),
      .RESET_PC (RPC)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.imem_ack      = 1'b0;
      bus.imem_rdata    = '0;
      bus.inst_legal    = 1'b1;
      bus.s_jump        = 1'b0;
      bus.s_jalr        = 1'b0;
      bus.s_branch      = 1'b0;
      bus.s_branch_zero = 1'b0;
      bus.s_load        = 1'b0;
      bus.s_store       = 1'b0;
      bus.imm           = '0;
      bus.rs1_data      = '0;
      bus.alu_result    = '0;
      bus.alu_zero      = 1'b0;
      bus.dmem_ack      = 1'b0;
   endtask

   // Leaves the bench in cycle 1 (FETCH) with rst low.
   task automatic do_reset();
      clear_inputs();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      clear_inputs();
      rst = 1'b1;
      step();
      step();
      n_vec++; if (bus.imem_req !== 1'b0) begin n_bad++; $display("FAIL reset_imem_req: got %0b want 0", bus.imem_req); end
      n_vec++; if (bus.pc !== RPC) begin n_bad++; $display("FAIL reset_pc: got %h want %h", bus.pc, RPC); end
      n_vec++; if (bus.inst !== 32'h0) begin n_bad++; $display("FAIL reset_inst: got %h want 0", bus.inst); end
      n_vec++; if (bus.trap !== 1'b0) begin n_bad++; $display("FAIL reset_trap: got %0b want 0", bus.trap); end
      n_vec++; if ({bus.rf_we, bus.retire, bus.dmem_req, bus.dmem_we} !== 4'b0000) begin n_bad++; $display("FAIL reset_strobes: got %b want 0000", {bus.rf_we, bus.retire, bus.dmem_req, bus.dmem_we}); end
      n_vec++; if (bus.wb_sel !== 2'd0) begin n_bad++; $display("FAIL reset_wb_sel: got %0d want 0", bus.wb_sel); end
      rst = 1'b0;
      #1;
      n_vec++; if (bus.imem_req !== 1'b1) begin n_bad++; $display("FAIL reset_release_imem_req: got %0b want 1", bus.imem_req); end
   endtask

   task automatic test_addi();
      do_reset();
      bus.imem_ack   = 1'b1;
      bus.imem_rdata = ADDI;
      // cycle 1: FETCH
      n_vec++; if (bus.imem_addr !== RPC) begin n_bad++; $display("FAIL addi_imem_addr: got %h want %h", bus.imem_addr, RPC); end
      step(); // cycle 2: DECODE
      bus.imem_ack = 1'b0;
      n_vec++; if (bus.inst !== ADDI) begin n_bad++; $display("FAIL addi_inst: got %h want %h", bus.inst, ADDI); end
      n_vec++; if (bus.imem_req !== 1'b0) begin n_bad++; $display("FAIL addi_decode_imem_req: got %0b want 0", bus.imem_req); end
      step(); // cycle 3: EXEC
      n_vec++; if ({bus.rf_we, bus.retire} !== 2'b00) begin n_bad++; $display("FAIL addi_exec_strobes: got %b want 00", {bus.rf_we, bus.retire}); end
      step(); // cycle 4: WB
      n_vec++; if ({bus.rf_we, bus.retire} !== 2'b11) begin n_bad++; $display("FAIL addi_wb_strobes: got %b want 11", {bus.rf_we, bus.retire}); end
      n_vec++; if (bus.wb_sel !== 2'd0) begin n_bad++; $display("FAIL addi_wb_sel: got %0d want 0", bus.wb_sel); end
      n_vec++; if (bus.pc !== RPC) begin n_bad++; $display("FAIL addi_wb_pc: got %h want %h", bus.pc, RPC); end
      step(); // cycle 5: next FETCH
      n_vec++; if (bus.imem_addr !== RPC + 32'd4) begin n_bad++; $display("FAIL addi_next_addr: got %h want %h", bus.imem_addr, RPC + 32'd4); end
      n_vec++; if ({bus.imem_req, bus.retire, bus.rf_we} !== 3'b100) begin n_bad++; $display("FAIL addi_next_strobes: got %b want 100", {bus.imem_req, bus.retire, bus.rf_we}); end
   endtask

   task automatic test_branch();
      // taken BEQ, imm = -8 -> 0x100 - 8 = 0xF8
      do_reset();
      bus.imem_ack = 1'b1; bus.imem_rdata = 32'hFE00_0CE3;
      bus.s_branch = 1'b1; bus.s_branch_zero = 1'b1; bus.alu_zero = 1'b1;
      bus.imm = 32'hFFFF_FFF8;
      step(); bus.imem_ack = 1'b0;
      step();
      step(); // WB
      n_vec++; if ({bus.rf_we, bus.retire} !== 2'b01) begin n_bad++; $display("FAIL beq_taken_wb: got %b want 01", {bus.rf_we, bus.retire}); end
      step();
      n_vec++; if (bus.pc !== 32'h0000_00F8) begin n_bad++; $display("FAIL beq_taken_pc: got %h want 000000f8", bus.pc); end
      // not taken: alu_zero=0 -> 0x104
      do_reset();
      bus.imem_ack = 1'b1; bus.imem_rdata = 32'hFE00_0CE3;
      bus.s_branch = 1'b1; bus.s_branch_zero = 1'b1; bus.alu_zero = 1'b0;
      bus.imm = 32'hFFFF_FFF8;
      step(); bus.imem_ack = 1'b0;
      step();
      step();
      n_vec++; if ({bus.rf_we, bus.retire} !== 2'b01) begin n_bad++; $display("FAIL beq_fall_wb: got %b want 01", {bus.rf_we, bus.retire}); end
      step();
      n_vec++; if (bus.pc !== 32'h0000_0104) begin n_bad++; $display("FAIL beq_fall_pc: got %h want 00000104", bus.pc); end
   endtask

   task automatic test_jalr();
      // rs1=0x205, imm=0 -> target 0x204 (bit 1 clear): retires as a link
      do_reset();
      bus.imem_ack = 1'b1; bus.imem_rdata = 32'h0000_80E7;
      bus.s_jump = 1'b1; bus.s_jalr = 1'b1; bus.rs1_data = 32'h0000_0205; bus.imm = '0;
      step(); bus.imem_ack = 1'b0;
      step();
      step(); // WB
      n_vec++; if ({bus.rf_we, bus.retire} !== 2'b11) begin n_bad++; $display("FAIL jalr_wb: got %b want 11", {bus.rf_we, bus.retire}); end
      n_vec++; if (bus.wb_sel !== 2'd2) begin n_bad++; $display("FAIL jalr_wb_sel: got %0d want 2", bus.wb_sel); end
      step();
      n_vec++; if (bus.pc !== 32'h0000_0204) begin n_bad++; $display("FAIL jalr_pc: got %h want 00000204", bus.pc); end
      // rs1=0x203 -> target 0x202, bit 1 set: trap, pc frozen, no retire
      do_reset();
      bus.imem_ack = 1'b1; bus.imem_rdata = 32'h0000_80E7;
      bus.s_jump = 1'b1; bus.s_jalr = 1'b1; bus.rs1_data = 32'h0000_0203; bus.imm = '0;
      step(); bus.imem_ack = 1'b0;
      step(); // EXEC
      step(); // TRAP
      n_vec++; if (bus.trap !== 1'b1) begin n_bad++; $display("FAIL jalr_mis_trap: got %0b want 1", bus.trap); end
      n_vec++; if ({bus.retire, bus.rf_we, bus.imem_req} !== 3'b000) begin n_bad++; $display("FAIL jalr_mis_strobes: got %b want 000", {bus.retire, bus.rf_we, bus.imem_req}); end
      step();
      step();
      n_vec++; if (bus.pc !== RPC) begin n_bad++; $display("FAIL jalr_mis_pc: got %h want %h", bus.pc, RPC); end
   endtask

   task automatic test_jal_wrap();
      // jal with imm = -0x200 from 0x100 wraps to 0xFFFFFF00
      do_reset();
      bus.imem_ack = 1'b1; bus.imem_rdata = 32'h0000_00EF;
      bus.s_jump = 1'b1; bus.imm = 32'hFFFF_FE00;
      step(); bus.imem_ack = 1'b0;
      step();
      step();
      n_vec++; if ({bus.rf_we, bus.retire, bus.wb_sel} !== 4'b1110) begin n_bad++; $display("FAIL jal_wb: got %b want 1110", {bus.rf_we, bus.retire, bus.wb_sel}); end
      step();
      n_vec++; if (bus.pc !== 32'hFFFF_FF00) begin n_bad++; $display("FAIL jal_wrap_pc: got %h want ffffff00", bus.pc); end
   endtask

   task automatic test_load();
      int retires;
      do_reset();
      retires = 0;
      bus.imem_ack = 1'b1; bus.imem_rdata = 32'h0000_A083; bus.s_load = 1'b1;
      step(); bus.imem_ack = 1'b0; // cycle 2
      step();                      // cycle 3
      // cycles 4..7: MEM, ack arrives in the fourth MEM cycle
      for (int i = 0; i < 4; i++) begin
         step();
         n_vec++; if ({bus.dmem_req, bus.dmem_we, bus.retire} !== 3'b100) begin n_bad++; $display("FAIL lw_mem_cycle%0d: got %b want 100", i, {bus.dmem_req, bus.dmem_we, bus.retire}); end
         if (i == 3) bus.dmem_ack = 1'b1;
      end
      step(); // cycle 8: WB
      bus.dmem_ack = 1'b0;
      n_vec++; if ({bus.dmem_req, bus.rf_we, bus.retire, bus.wb_sel} !== 5'b01101) begin n_bad++; $display("FAIL lw_wb: got %b want 01101", {bus.dmem_req, bus.rf_we, bus.retire, bus.wb_sel}); end
      step(); // cycle 9: next FETCH
      n_vec++; if ({bus.imem_req, bus.pc} !== {1'b1, RPC + 32'd4}) begin n_bad++; $display("FAIL lw_next: got %b/%h want 1/%h", bus.imem_req, bus.pc, RPC + 32'd4); end
   endtask

   task automatic test_store();
      // dmem_ack held high from the start: only the MEM-state ack counts
      do_reset();
      bus.imem_ack = 1'b1; bus.imem_rdata = 32'h0010_A023; bus.s_store = 1'b1;
      bus.dmem_ack = 1'b1;
      step(); bus.imem_ack = 1'b0;
      n_vec++; if (bus.dmem_req !== 1'b0) begin n_bad++; $display("FAIL sw_decode_dmem_req: got %0b want 0", bus.dmem_req); end
      step();
      step(); // MEM
      n_vec++; if ({bus.dmem_req, bus.dmem_we} !== 2'b11) begin n_bad++; $display("FAIL sw_mem: got %b want 11", {bus.dmem_req, bus.dmem_we}); end
      step(); // WB
      n_vec++; if ({bus.dmem_req, bus.rf_we, bus.retire} !== 3'b001) begin n_bad++; $display("FAIL sw_wb: got %b want 001", {bus.dmem_req, bus.rf_we, bus.retire}); end
      bus.dmem_ack = 1'b0;
   endtask

   task automatic test_illegal();
      do_reset();
      bus.imem_ack = 1'b1; bus.imem_rdata = 32'hFFFF_FFFF; bus.inst_legal = 1'b0;
      step(); // DECODE
      n_vec++; if (bus.trap !== 1'b0) begin n_bad++; $display("FAIL ill_decode_trap: got %0b want 0", bus.trap); end
      bus.imem_rdata = 32'h1234_5678;
      bus.dmem_ack   = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         n_vec++; if ({bus.trap, bus.imem_req, bus.retire, bus.rf_we, bus.dmem_req} !== 5'b10000) begin n_bad++; $display("FAIL ill_trap_cycle%0d: got %b want 10000", i, {bus.trap, bus.imem_req, bus.retire, bus.rf_we, bus.dmem_req}); end
      end
      n_vec++; if ({bus.pc, bus.inst} !== {RPC, 32'hFFFF_FFFF}) begin n_bad++; $display("FAIL ill_frozen: got %h/%h want %h/ffffffff", bus.pc, bus.inst, RPC); end
      rst = 1'b1;
      step();
      n_vec++; if ({bus.trap, bus.imem_req} !== 2'b00) begin n_bad++; $display("FAIL ill_rst: got %b want 00", {bus.trap, bus.imem_req}); end
      rst = 1'b0;
      #1;
      n_vec++; if ({bus.imem_req, bus.imem_addr} !== {1'b1, RPC}) begin n_bad++; $display("FAIL ill_refetch: got %b/%h want 1/%h", bus.imem_req, bus.imem_addr, RPC); end
      clear_inputs();
   endtask

   task automatic test_reset_in_mem();
      // retire one ADDI so pc moves off RESET_PC, then abort a stalled load
      do_reset();
      bus.imem_ack = 1'b1; bus.imem_rdata = ADDI;
      step(); bus.imem_ack = 1'b0;
      step();
      step();
      step(); // FETCH at 0x104
      bus.imem_ack = 1'b1; bus.imem_rdata = 32'h0000_A083; bus.s_load = 1'b1;
      step(); bus.imem_ack = 1'b0;
      step();
      step(); // MEM, no ack
      n_vec++; if ({bus.dmem_req, bus.pc} !== {1'b1, RPC + 32'd4}) begin n_bad++; $display("FAIL rstmem_pre: got %b/%h want 1/%h", bus.dmem_req, bus.pc, RPC + 32'd4); end
      rst = 1'b1;
      step();
      rst = 1'b0;
      #1;
      n_vec++; if ({bus.dmem_req, bus.retire, bus.imem_req} !== 3'b001) begin n_bad++; $display("FAIL rstmem_strobes: got %b want 001", {bus.dmem_req, bus.retire, bus.imem_req}); end
      n_vec++; if (bus.imem_addr !== RPC) begin n_bad++; $display("FAIL rstmem_pc: got %h want %h", bus.imem_addr, RPC); end
   endtask

   task automatic test_back_to_back();
      int retires;
      do_reset();
      retires = 0;
      bus.imem_ack = 1'b1; bus.imem_rdata = ADDI; // held high throughout
      for (int i = 1; i <= 12; i++) begin
         if (i > 1) step();
         if (bus.retire === 1'b1) retires++;
      end
      n_vec++; if (retires !== 3) begin n_bad++; $display("FAIL b2b_retires: got %0d want 3", retires); end
      step();
      n_vec++; if (bus.pc !== RPC + 32'd12) begin n_bad++; $display("FAIL b2b_pc: got %h want %h", bus.pc, RPC + 32'd12); end
   endtask

   initial begin
      n_vec = 0;
      n_bad = 0;
      rst   = 1'b1;
      clear_inputs();
      test_reset();
      test_addi();
      test_branch();
      test_jalr();
      test_jal_wrap();
      test_load();
      test_store();
      test_illegal();
      test_reset_in_mem();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
